// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream
// interface. A WIDTH-bit operation is split into NSEG = WIDTH/SEG_W segments.
// Stage k resolves segment k with a chain of 4-bit lookahead groups, and the
// carry out of each segment is registered on its way to the next stage. Operand
// bits for later segments travel with the beat, and finished sum bits travel
// forward, so a new beat can enter every clock.
//
// Parameters
//   WIDTH  operand/result width, a multiple of SEG_W
//   SEG_W  bits resolved per stage, a multiple of 4
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset; discards every in-flight beat
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   op         0 = add (a + b + ci), 1 = subtract (a - b - ci)
//   a, b       operands
//   ci         carry-in for add, borrow-in for subtract
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   s          WIDTH-bit result
//   co         carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       s == 0
//
// Latency is NSEG register stages with no stalls; throughput is one beat/clock.
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
  parameter int WIDTH = 64,
  parameter int SEG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int NGRP = SEG_W / 4;

  // One pipeline slot. bx is the effective addend (b or ~b) and c is the carry
  // into the next unresolved segment. The flags are only meaningful once every
  // segment has been resolved, i.e. in the last slot.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             ovf;
    logic             zero;
  } beat_t;

  // One segment: 4-bit lookahead groups (g = x&y, p = x|y), with the group
  // carries rippling from group to group. Returns {carry_out, sum}.
  function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x,
                                             input logic [SEG_W-1:0] y,
                                             input logic             cin);
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    g    = x & y;
    p    = x | y;
    c    = '0;
    c[0] = cin;
    for (int j = 0; j < NGRP; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      // Group generate/propagate form of the carry out of this group.
      c[4*j+4] = (g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                 | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]))
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
    end
    return {c[SEG_W], x ^ y ^ c[SEG_W-1:0]};
  endfunction

  beat_t            in_beat;
  beat_t            stage_in [NSEG];
  beat_t            pipe_d   [NSEG];
  beat_t            pipe_q   [NSEG];
  logic [SEG_W:0]   seg_res;
  logic             advance;

  // The whole pipe moves together: it can shift whenever the output slot is
  // empty or being drained this cycle.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    in_beat       = '0;
    seg_res       = '0;
    in_beat.valid = in_valid;
    in_beat.a     = a;
    // Subtraction is a + ~b + ~ci: invert the addend and the borrow up front.
    in_beat.bx    = op ? ~b : b;
    in_beat.c     = op ? ~ci : ci;

    stage_in[0] = in_beat;
    for (int k = 1; k < NSEG; k++) begin
      stage_in[k] = pipe_q[k-1];
    end

    for (int k = 0; k < NSEG; k++) begin
      pipe_d[k] = stage_in[k];
      seg_res   = seg_add(stage_in[k].a[k*SEG_W +: SEG_W],
                          stage_in[k].bx[k*SEG_W +: SEG_W],
                          stage_in[k].c);
      pipe_d[k].sum[k*SEG_W +: SEG_W] = seg_res[SEG_W-1:0];
      pipe_d[k].c    = seg_res[SEG_W];
      pipe_d[k].ovf  = (stage_in[k].a[WIDTH-1] == stage_in[k].bx[WIDTH-1]) &
                       (pipe_d[k].sum[WIDTH-1] != stage_in[k].a[WIDTH-1]);
      pipe_d[k].zero = (pipe_d[k].sum == '0);
    end
  end

  // NOTE: the datapath is reset along with the valid bits because the last
  // slot drives s/co/ovf/zero directly and those must read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NSEG; k++) begin
        pipe_q[k] <= '0;
      end
    end else if (advance) begin
      // NOTE: non-blocking assignments so every slot loads the value its
      // predecessor held before this edge, giving a true shift.
      for (int k = 0; k < NSEG; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign out_valid = pipe_q[NSEG-1].valid;
  assign s         = pipe_q[NSEG-1].sum;
  assign co        = pipe_q[NSEG-1].c;
  assign ovf       = pipe_q[NSEG-1].ovf;
  assign zero      = pipe_q[NSEG-1].zero;

endmodule
